// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and
// its MULT/DIV sequencer.
package hazard_pkg;

    localparam int COUNT_W        = 6;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Occupancy sequencer for the multi-cycle MULT/DIV unit: IDLE -> BUSY
// (counting down) -> DONE (one-cycle HI/LO write) -> IDLE or BUSY again.
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output fsm_state_t         state
);

    // The first busy cycle already shows count = cycles-2, so the unit
    // spends (cycles-2)+1 cycles in BUSY and the write lands at t+cycles.
    localparam logic [COUNT_W-1:0] MUL_LOAD = COUNT_W'(MUL_CYCLES - 2);
    localparam logic [COUNT_W-1:0] DIV_LOAD = COUNT_W'(DIV_CYCLES - 2);

    fsm_state_t         state_q;
    fsm_state_t         state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] load_val;

    assign load_val = op ? DIV_LOAD : MUL_LOAD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    count_d = load_val;
                end
            end
            // A start seen while BUSY is illegal (ID is stalled) and is ignored.
            BUSY: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = BUSY;
                    count_d = load_val;
                end else begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign busy  = (state_q == BUSY);
    assign done  = (state_q == DONE);
    assign count = busy ? count_q : '0;
    assign state = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: load-use and HI/LO
// stalls, branch flush, and sequencing of the MULT/DIV unit.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemRead_ex,
    input  logic [4:0]         RegWriteAddr_ex,
    input  logic [4:0]         RsAddr_id,
    input  logic [4:0]         RtAddr_id,
    input  logic               UsesRs_id,
    input  logic               UsesRt_id,
    input  logic               HiLoRead_id,
    input  logic               MulDiv_id,
    input  logic               MulDivStart_ex,
    input  logic               MulDivOp_ex,
    input  logic               Branch_taken_id,
    output logic               Stall_pc,
    output logic               Stall_ifid,
    output logic               Bubble_idex,
    output logic               Flush_ifid,
    output logic               MulDivBusy,
    output logic               HiLoWrite,
    output logic [COUNT_W-1:0] MulDivCount
);

    logic               seq_busy;
    logic               seq_done;
    logic [COUNT_W-1:0] seq_count;
    fsm_state_t         seq_state;
    logic               load_use;
    logic               hilo_hazard;
    logic               stall;

    muldiv_seq #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_seq (
        .clk  (clk),
        .reset(reset),
        .start(MulDivStart_ex),
        .op   (MulDivOp_ex),
        .busy (seq_busy),
        .done (seq_done),
        .count(seq_count),
        .state(seq_state)
    );

    // $0 is never a real destination, so a load into it creates no hazard.
    assign load_use = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                      ((UsesRs_id && (RsAddr_id == RegWriteAddr_ex)) ||
                       (UsesRt_id && (RtAddr_id == RegWriteAddr_ex)));

    // HI/LO consumers wait from the issue cycle through the last BUSY cycle;
    // in DONE the result is written before the reader reaches EX.
    assign hilo_hazard = (HiLoRead_id || MulDiv_id) &&
                         (seq_busy || ((seq_state == IDLE) && MulDivStart_ex));

    assign stall = load_use || hilo_hazard;

    assign Stall_pc    = stall;
    assign Stall_ifid  = stall;
    assign Bubble_idex = stall;
    // A stalled branch stays in ID and resolves again next cycle.
    assign Flush_ifid  = Branch_taken_id && !stall;

    assign MulDivBusy  = seq_busy;
    assign HiLoWrite   = seq_done;
    assign MulDivCount = seq_count;

endmodule
